// File: rtl/modinv_pkg.sv
// -----------------------------------------------------------------------------
// modinv_pkg
// Shared definitions for the modular-inverse engine:
//   - state_e        : controller states
//   - DEFAULT_WIDTH  : default operand/result width
//   - DEFAULT_ITER_W : default width of the optional division-step counter
// -----------------------------------------------------------------------------
package modinv_pkg;

  localparam int DEFAULT_WIDTH  = 64;
  localparam int DEFAULT_ITER_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    DIVIDE = 3'd2,
    UPDATE = 3'd3,
    FIXUP  = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage : modinv_pkg

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider producing one quotient bit per clock.
// Results are valid, with div_done high, exactly WIDTH cycles after the cycle
// in which div_start is asserted. The first quotient bit is produced on the
// load edge itself, so only WIDTH-1 further edges are needed.
// A zero divisor yields quotient = all-ones and remainder = dividend.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (aborts a running division)
//   div_start  in   load dividend/divisor and begin
//   dividend   in   [WIDTH-1:0] unsigned dividend
//   divisor    in   [WIDTH-1:0] unsigned divisor
//   quotient   out  [WIDTH-1:0] quotient, valid with div_done
//   remainder  out  [WIDTH-1:0] remainder, valid with div_done
//   div_done   out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_divider
  import modinv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Partial remainder, dividend/quotient shift register, held divisor.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic             done_q;

  logic [WIDTH-1:0] step_p, step_q, step_d;
  logic [WIDTH:0]   trial;
  logic             ge;

  // One restoring step. On div_start the step operates on the fresh operands
  // so the first quotient bit is produced on the load edge.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    step_p = p_q;
    step_q = q_q;
    step_d = d_q;
    if (div_start) begin
      step_p = '0;
      step_q = dividend;
      step_d = divisor;
    end
    trial = {step_p, step_q[WIDTH-1]};
    ge    = (trial >= {1'b0, step_d});
    // When ge holds the true difference is < divisor, so the low WIDTH bits
    // of the modular subtraction are exact.
    p_d   = ge ? (trial[WIDTH-1:0] - step_d) : trial[WIDTH-1:0];
    q_d   = {step_q[WIDTH-2:0], ge};
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div_start) begin
        p_q      <= p_d;
        q_q      <= q_d;
        d_q      <= divisor;
        cnt_q    <= CNT_W'(1);
        active_q <= 1'b1;
      end else if (active_q) begin
        p_q   <= p_d;
        q_q   <= q_d;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = q_q;
  assign remainder = p_q;
  assign div_done  = done_q;

endmodule : seq_divider

// File: rtl/modinv_engine.sv
// -----------------------------------------------------------------------------
// modinv_engine
// Multi-cycle extended-Euclidean engine computing gcd(a, m) and a^-1 mod m.
// Each Euclid step performs one WIDTH-cycle division in seq_divider, so a step
// costs WIDTH+2 cycles (CHECK, DIVIDE, UPDATE). The inverse is normalised into
// [0, m-1]; err flags gcd != 1 or m < 2, in which case inv is 0.
//
// Optional feature (macro MODINV_ITER_CNT_EN): adds output iter_cnt, the
// number of division steps, saturating at all-ones.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   request, sampled only in IDLE
//   a         in   [WIDTH-1:0] value to invert (a >= m allowed)
//   m         in   [WIDTH-1:0] modulus
//   busy      out  high from the cycle after accept until done
//   done      out  one-cycle pulse, results valid from this cycle
//   inv       out  [WIDTH-1:0] a^-1 mod m, 0 on err
//   gcd       out  [WIDTH-1:0] gcd(a, m)
//   err       out  no inverse exists
//   iter_cnt  out  [ITER_W-1:0] division steps (MODINV_ITER_CNT_EN only)
// -----------------------------------------------------------------------------
module modinv_engine
  import modinv_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ITER_W = DEFAULT_ITER_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  m,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  inv,
  output logic [WIDTH-1:0]  gcd,
  output logic              err
`ifdef MODINV_ITER_CNT_EN
  ,
  output logic [ITER_W-1:0] iter_cnt
`endif
);

  if (WIDTH < 4 || ITER_W < 1) begin : g_bad_param
    $error("modinv_engine: WIDTH must be >= 4 and ITER_W >= 1");
  end

  state_e state_q, state_d;

  // Remainder pair, captured modulus and registered results.
  logic [WIDTH-1:0] r0_q, r0_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             err_q, err_d;

  // Bezout coefficients of a; |t| <= m so WIDTH+1 signed bits suffice.
  logic signed [WIDTH:0] t0_q, t0_d;
  logic signed [WIDTH:0] t1_q, t1_d;

  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  logic signed [WIDTH:0] quo_s;
  logic signed [WIDTH:0] t_next;
  logic signed [WIDTH:0] t0_plus_m;
  logic                  fix_err;

  seq_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .div_start (div_start),
    .dividend  (r0_q),
    .divisor   (r1_q),
    .quotient  (div_quo),
    .remainder (div_rem),
    .div_done  (div_done)
  );

  // The product is evaluated at WIDTH+1 bits; wraparound cancels because the
  // exact result t0 - q*t1 fits in WIDTH+1 signed bits.
  assign quo_s     = signed'({1'b0, div_quo});
  assign t_next    = t0_q - quo_s * t1_q;
  assign t0_plus_m = t0_q + signed'({1'b0, m_q});
  assign fix_err   = (r0_q != WIDTH'(1)) || (m_q < WIDTH'(2));

  always_comb begin
    state_d   = state_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    m_d       = m_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    inv_d     = inv_q;
    gcd_d     = gcd_q;
    err_d     = err_q;
    div_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          r0_d    = m;
          r1_d    = a;
          m_d     = m;
          t0_d    = '0;
          t1_d    = {{WIDTH{1'b0}}, 1'b1};
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (r1_q == '0) begin
          state_d = FIXUP;
        end else begin
          div_start = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) state_d = UPDATE;
      end
      UPDATE: begin
        r0_d    = r1_q;
        r1_d    = div_rem;
        t0_d    = t1_q;
        t1_d    = t_next;
        state_d = CHECK;
      end
      FIXUP: begin
        gcd_d = r0_q;
        err_d = fix_err;
        if (fix_err) begin
          inv_d = '0;
        end else if (t0_q[WIDTH]) begin
          inv_d = t0_plus_m[WIDTH-1:0];
        end else begin
          inv_d = t0_q[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      m_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      inv_q   <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      m_q     <= m_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      inv_q   <= inv_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign inv  = inv_q;
  assign gcd  = gcd_q;
  assign err  = err_q;

`ifdef MODINV_ITER_CNT_EN
  logic [ITER_W-1:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (state_q == IDLE && start) begin
      iter_d = '0;
    end else if (state_q == UPDATE && iter_q != '1) begin
      iter_d = iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) iter_q <= '0;
    else          iter_q <= iter_d;
  end

  assign iter_cnt = iter_q;
`else
  // Step counter not built; ITER_W only feeds the parameter sanity check.
`endif

endmodule : modinv_engine
